cmd_loader: RTL and testbench

Program loader that writes the core's instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles 39-bit command words. It writes each word into consecutive instruction-memory addresses from 0 and holds the core in reset until a complete, checksum-verified program is loaded. It drives the write port of the same command memory the core reads, and its `core_hold` output is ORed into the core's reset.

---
 rtl/cmd_loader_pkg.sv | 19 +
 rtl/cmd_loader_byte_packer.sv | 45 ++++
 rtl/cmd_loader.sv | 124 ++++++++++++
 tb/tb_cmd_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_loader_pkg.sv
// Shared cpu constants for the command memory and the loader state encoding.
package cmd_loader_pkg;

    localparam int unsigned CMD_WIDTH      = 39;
    localparam int unsigned CMD_ADDR_WIDTH = 6;
    localparam int unsigned BYTES_PER_CMD  = (CMD_WIDTH + 7) / 8;
    localparam int unsigned CMD_DEPTH      = 2 ** CMD_ADDR_WIDTH;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COUNT,
        LD_DATA,
        LD_WRITE,
        LD_CHECK,
        LD_DONE,
        LD_ERROR
    } ld_state_t;

endpackage

// File: rtl/cmd_loader_byte_packer.sv
// Shifts bytes MSB-first into a WIDTH-bit word and flags the byte that completes it.
// Bits shifted above WIDTH-1 fall off, so the top of the first byte is ignored.
module byte_packer #(
    parameter int unsigned WIDTH  = 39,
    parameter int unsigned NBYTES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic             full_o
);

    localparam int unsigned CW = $clog2(NBYTES + 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign full_o = shift_i && (cnt_q == CW'(NBYTES - 1));
    assign word_o = sr_q;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            sr_d  = {sr_q[WIDTH-9:0], byte_i};
            cnt_d = full_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_loader.sv
// Loads a framed, XOR-checked byte stream into instruction memory and holds
// the core in reset until a complete program has been verified.
module cmd_loader
    import cmd_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      mem_wen,
    output logic [CMD_ADDR_WIDTH-1:0] mem_addr,
    output logic [CMD_WIDTH-1:0]      mem_wdata,
    output logic                      core_hold,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [CMD_ADDR_WIDTH:0]   words_loaded
);

    ld_state_t                 state_q, state_d;
    logic [CMD_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CMD_ADDR_WIDTH:0]   words_q, words_d, words_inc;
    logic [CMD_ADDR_WIDTH:0]   n_q, n_d;
    logic [7:0]                xor_q, xor_d;
    logic                      accept, count_bad, start_ok;
    logic                      pk_clear, pk_shift, pk_full;
    logic [CMD_WIDTH-1:0]      pk_word;

    // Every output is decoded from state or taken from a register.
    assign in_ready     = (state_q == LD_COUNT) || (state_q == LD_DATA) || (state_q == LD_CHECK);
    assign busy         = in_ready || (state_q == LD_WRITE);
    assign mem_wen      = (state_q == LD_WRITE);
    assign core_hold    = (state_q != LD_DONE);
    assign done         = (state_q == LD_DONE);
    assign err          = (state_q == LD_ERROR);
    assign mem_addr     = addr_q;
    assign mem_wdata    = pk_word;
    assign words_loaded = words_q;

    assign accept    = in_valid && in_ready;
    assign count_bad = (in_data == 8'd0) || ({1'b0, in_data} > 9'(CMD_DEPTH));
    assign words_inc = words_q + 1'b1;
    assign start_ok  = start && ((state_q == LD_IDLE) || (state_q == LD_DONE) || (state_q == LD_ERROR));

    byte_packer #(
        .WIDTH  (CMD_WIDTH),
        .NBYTES (BYTES_PER_CMD)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (pk_clear),
        .shift_i (pk_shift),
        .byte_i  (in_data),
        .word_o  (pk_word),
        .full_o  (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        words_d  = words_q;
        n_d      = n_q;
        xor_d    = xor_q;
        pk_clear = 1'b0;
        pk_shift = 1'b0;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start_ok) begin
                    state_d  = LD_COUNT;
                    addr_d   = '0;
                    words_d  = '0;
                    xor_d    = '0;
                    pk_clear = 1'b1;
                end
            end
            LD_COUNT: begin
                if (accept) begin
                    xor_d = in_data;
                    if (count_bad) begin
                        state_d = LD_ERROR;
                    end else begin
                        n_d     = in_data[CMD_ADDR_WIDTH:0];
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (accept) begin
                    pk_shift = 1'b1;
                    xor_d    = xor_q ^ in_data;
                    if (pk_full) state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                addr_d  = addr_q + 1'b1;
                words_d = words_inc;
                state_d = (words_inc == n_q) ? LD_CHECK : LD_DATA;
            end
            LD_CHECK: begin
                if (accept) state_d = (in_data == xor_q) ? LD_DONE : LD_ERROR;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            words_q <= '0;
            n_q     <= '0;
            xor_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            n_q     <= n_d;
            xor_q   <= xor_d;
        end
    end

endmodule

// File: tb/tb_cmd_loader.sv
// Scoreboarded random/directed bench for the program loader.
module tb_cmd_loader;
    import cmd_loader_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset, start, in_valid, in_ready;
    logic [7:0]                in_data;
    logic                      mem_wen, core_hold, busy, done, err;
    logic [CMD_ADDR_WIDTH-1:0] mem_addr;
    logic [CMD_WIDTH-1:0]      mem_wdata;
    logic [CMD_ADDR_WIDTH:0]   words_loaded;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CMD_ADDR_WIDTH-1:0] addr;
        logic [CMD_WIDTH-1:0]      data;
    } wr_t;

    wr_t         exp_q[$];
    logic [39:0] frame_words[$];
    bit          gaps     = 0;
    int          start_at = -1;

    cmd_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_wen must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && mem_wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
                chk("wr_in_ready_low", 64'(in_ready), 64'(0));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sends a frame with COUNT=cnt using frame_words; CHK is XORed with chk_flip.
    task automatic load(input logic [7:0] cnt, input logic [7:0] chk_flip);
        int          n, bi;
        bit          ok, good;
        logic [7:0]  x, b;
        logic [39:0] v;
        n    = int'(cnt);
        ok   = (n >= 1) && (n <= int'(CMD_DEPTH));
        good = ok && (chk_flip == 8'h00);
        bi   = 0;
        pulse_start();
        chk("ready_after_start", 64'(in_ready), 64'(1));
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("hold_after_start", 64'(core_hold), 64'(1));
        chk("flags_cleared", 64'({done, err}), 64'(0));
        chk("words_cleared", 64'(words_loaded), 64'(0));
        x = cnt;
        send_byte(cnt);
        if (!ok) begin
            chk("badcnt_err", 64'(err), 64'(1));
            chk("badcnt_done", 64'(done), 64'(0));
            chk("badcnt_ready", 64'(in_ready), 64'(0));
            chk("badcnt_hold", 64'(core_hold), 64'(1));
            return;
        end
        for (int w = 0; w < n; w++) begin
            v = frame_words[w];
            exp_q.push_back('{addr: CMD_ADDR_WIDTH'(w), data: v[CMD_WIDTH-1:0]});
            for (int k = 4; k >= 0; k--) begin
                b = v[k*8 +: 8];
                x ^= b;
                send_byte(b);
                bi++;
                if (bi == start_at || bi == start_at + 2) pulse_start();
            end
        end
        send_byte(x ^ chk_flip);
        chk("end_done", 64'(done), 64'(good));
        chk("end_err", 64'(err), 64'(!good));
        chk("end_hold", 64'(core_hold), 64'(!good));
        chk("end_busy", 64'(busy), 64'(0));
        chk("end_words", 64'(words_loaded), 64'(n));
        chk("end_addr", 64'(mem_addr), 64'(n % int'(CMD_DEPTH)));
        chk("writes_seen", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic rand_words(input int n);
        logic [39:0] r;
        frame_words.delete();
        for (int i = 0; i < n; i++) begin
            r[31:0]  = $urandom;
            r[39:32] = 8'($urandom);
            frame_words.push_back(r);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hold", 64'(core_hold), 64'(1));
        chk("rst_ctrl", 64'({in_ready, mem_wen, busy, done, err}), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_words", 64'(words_loaded), 64'(0));

        // Single word 0x2A, CHK 2B.
        frame_words.delete();
        frame_words.push_back(40'h00_0000_002A);
        load(8'h01, 8'h00);

        // Same frame with CHK 00.
        load(8'h01, 8'h2B);

        // Illegal counts.
        load(8'h00, 8'h00);
        load(8'h41, 8'h00);
        load(8'hFF, 8'h00);

        // Three words with in_valid toggling.
        gaps = 1;
        rand_words(3);
        load(8'h03, 8'h00);

        // Full memory, address wraps back to 0.
        rand_words(64);
        load(8'h40, 8'h00);

        // Reset after the 3rd data byte of a frame.
        gaps = 0;
        pulse_start();
        send_byte(8'h03);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        chk("abort_hold", 64'(core_hold), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_hold_after", 64'(core_hold), 64'(1));
        chk("abort_state", 64'({busy, done, err, in_ready}), 64'(0));
        chk("abort_words", 64'(words_loaded), 64'(0));
        chk("abort_addr", 64'(mem_addr), 64'(0));
        repeat (3) @(negedge clk);
        rand_words(2);
        load(8'h02, 8'h00);

        // start pulsed during DATA and WRITE is ignored.
        start_at = 5;
        rand_words(3);
        load(8'h03, 8'h00);
        start_at = -1;

        // Random frames.
        gaps = 1;
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 8);
            rand_words(n);
            load(8'(n), ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        end

        repeat (3) @(negedge clk);
        chk("final_no_pending", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
